// File: rtl/dma_wr_pkg.sv
// dma_wr_pkg: shared types for the output-feature-map write DMA scheduler
package dma_wr_pkg;
  localparam int FAIL_CNT_W = 16;
  localparam int DESC_AD_W = 32;
  localparam int DESC_LEN_W = 13;
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_DONE} state_t;
  typedef struct packed {
    logic [DESC_AD_W-1:0]  addr;
    logic [DESC_LEN_W-1:0] len;
  } desc_t;
endpackage

// File: rtl/dma_wr_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int REQ_IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [REQ_IDX_W-1:0] ptr,
  input  logic                 en,
  output logic [NUM_REQ-1:0]   grant,
  output logic [REQ_IDX_W-1:0] idx,
  output logic                 any
);
  // scanning from the farthest slot down lets the nearest hit win
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (en && req[(int'(ptr) + i) % NUM_REQ]) begin
        any = 1'b1;
        idx = REQ_IDX_W'((int'(ptr) + i) % NUM_REQ);
      end
  end
  assign grant = any ? NUM_REQ'(1) << idx : '0;
endmodule

// File: rtl/dma_wr_sched.sv
// dma_wr_sched: round-robin sharing of the single write DMA among NUM_REQ requesters
module dma_wr_sched import dma_wr_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int AXI_WIDTH_AD = DESC_AD_W,
  parameter int AXI_WIDTH_DA = 32,
  parameter int OUT_BITS_TRANS = DESC_LEN_W,
  localparam int REQ_IDX_W = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sched_en_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [NUM_REQ*AXI_WIDTH_AD-1:0]   req_addr_i,
  input  logic [NUM_REQ*OUT_BITS_TRANS-1:0] req_len_i,
  input  logic [NUM_REQ*AXI_WIDTH_DA-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]                req_data_pop_o,
  output logic [NUM_REQ-1:0]                req_done_o,
  output logic [NUM_REQ-1:0]                req_err_o,
  output logic                              dma_start_o,
  output logic [OUT_BITS_TRANS-1:0]         dma_num_trans_o,
  output logic [AXI_WIDTH_AD-1:0]           dma_start_addr_o,
  output logic [AXI_WIDTH_DA-1:0]           dma_indata_o,
  input  logic                              dma_indata_req_i,
  input  logic                              dma_done_i,
  input  logic                              dma_fail_i,
  output logic                              busy_o,
  output logic [REQ_IDX_W-1:0]              grant_idx_o,
  output logic [FAIL_CNT_W-1:0]             fail_cnt_o
);
  state_t state, state_n;
  desc_t desc;
  logic [REQ_IDX_W-1:0] g, ptr, gi;
  logic err, any, run;
  logic [NUM_REQ-1:0][AXI_WIDTH_AD-1:0] addr_a;
  logic [NUM_REQ-1:0][OUT_BITS_TRANS-1:0] len_a;
  logic [NUM_REQ-1:0][AXI_WIDTH_DA-1:0] data_a;
  assign addr_a = req_addr_i;
  assign len_a = req_len_i;
  assign data_a = req_data_i;
  // rst gates the arbiter so no accept strobe leaks out while held in reset
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(req_valid_i),
    .ptr(ptr),
    .en(sched_en_i && state == S_IDLE && !rst),
    .grant(req_ready_o),
    .idx(gi),
    .any(any)
  );
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   state_n = !any ? S_IDLE : (len_a[gi] == '0 ? S_DONE : S_LAUNCH);
      S_LAUNCH: state_n = S_RUN;
      S_RUN:    state_n = dma_done_i ? S_DONE : S_RUN;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end
  assign run = state == S_RUN;
  assign busy_o = state != S_IDLE;
  assign dma_start_o = state == S_LAUNCH;
  assign dma_indata_o = run ? data_a[g] : '0;
  assign req_data_pop_o = run && dma_indata_req_i ? NUM_REQ'(1) << g : '0;
  assign req_done_o = state == S_DONE ? NUM_REQ'(1) << g : '0;
  assign req_err_o = req_done_o & {NUM_REQ{err}};
  assign dma_num_trans_o = OUT_BITS_TRANS'(desc.len);
  assign dma_start_addr_o = AXI_WIDTH_AD'(desc.addr);
  assign grant_idx_o = g;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      desc <= '0;
      g <= '0;
      ptr <= '0;
      err <= 1'b0;
      fail_cnt_o <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && any) begin
        desc <= '{addr: DESC_AD_W'(addr_a[gi]), len: DESC_LEN_W'(len_a[gi])};
        g <= gi;
      end
      if (run && dma_fail_i) begin
        err <= 1'b1;
        if (~&fail_cnt_o) fail_cnt_o <= fail_cnt_o + 1'b1;
      end
      if (state == S_DONE) begin
        err <= 1'b0;
        ptr <= g == REQ_IDX_W'(NUM_REQ - 1) ? '0 : g + 1'b1;
      end
    end
  end
endmodule
